// File: rtl/dadda_mult_pipe.sv
// Three-stage pipelined multiplier: registered operands, Dadda tree reduced to two rows,
// then a carry-propagate add. Baugh-Wooley partial products give exact signed products.
module dadda_mult_pipe #(
  parameter int WIDTH     = 8,
  parameter int SIGNED_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_signed
);

  localparam int   NCOL   = 2 * WIDTH;
  localparam int   MAXH   = WIDTH + 2;
  localparam int   NLVL   = 9;
  localparam logic SGN_OK = (SIGNED_EN != 0);

  function automatic int dadda_height(input int lvl);
    int d;
    d = 2;
    for (int k = 0; k < lvl; k++) d = (d * 3) / 2;
    return d;
  endfunction

  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  logic                 stall;
  logic                 v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [WIDTH-1:0]     a1_q, a1_d, b1_q, b1_d;
  logic                 sgn1_q, sgn1_d, sgn2_q, sgn2_d, sgn3_q, sgn3_d;
  logic [NCOL-1:0]      sum2_q, sum2_d, carry2_q, carry2_d;
  logic [NCOL-1:0]      p3_q, p3_d;

  logic [NCOL-1:0]      red_sum, red_carry;
  logic [MAXH-1:0]      col_cur [NCOL+1];
  logic [MAXH-1:0]      col_nxt [NCOL+1];
  int                   n_cur   [NCOL+1];
  int                   n_nxt   [NCOL+1];
  int                   lvl_d, col_h;
  logic                 pp_bit;
  logic [1:0]           add_r;

  assign stall      = v3_q & ~out_ready;
  assign in_ready   = ~stall;
  assign out_valid  = v3_q;
  assign out_p      = p3_q;
  assign out_signed = sgn3_q;

  // Partial-product matrix and Dadda reduction, all between S1 and S2.
  // Columns are packed bit-bags: bits are consumed from bit 0 and appended at the top.
  always_comb begin
    for (int c = 0; c <= NCOL; c++) begin
      col_cur[c] = '0;
      n_cur[c]   = 0;
      col_nxt[c] = '0;
      n_nxt[c]   = 0;
    end
    lvl_d  = 0;
    col_h  = 0;
    pp_bit = 1'b0;
    add_r  = 2'b00;

    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp_bit = a1_q[j] & b1_q[i];
        if (sgn1_q && ((i == WIDTH-1) != (j == WIDTH-1))) pp_bit = ~pp_bit;
        col_cur[i+j] = col_cur[i+j] | (MAXH'(pp_bit) << n_cur[i+j]);
        n_cur[i+j]   = n_cur[i+j] + 1;
      end
    end
    col_cur[WIDTH]  = col_cur[WIDTH] | (MAXH'(sgn1_q) << n_cur[WIDTH]);
    n_cur[WIDTH]    = n_cur[WIDTH] + 1;
    col_cur[NCOL-1] = col_cur[NCOL-1] | (MAXH'(sgn1_q) << n_cur[NCOL-1]);
    n_cur[NCOL-1]   = n_cur[NCOL-1] + 1;

    // Levels whose target is above the current height do nothing, so all are walked.
    for (int lvl = NLVL-1; lvl >= 0; lvl--) begin
      lvl_d = dadda_height(lvl);
      for (int c = 0; c <= NCOL; c++) begin
        col_nxt[c] = '0;
        n_nxt[c]   = 0;
      end
      for (int c = 0; c < NCOL; c++) begin
        col_h = n_cur[c] + n_nxt[c];
        for (int k = 0; k < MAXH; k++) begin
          if (col_h > lvl_d && n_cur[c] >= 2) begin
            if (col_h == lvl_d + 1 || n_cur[c] == 2) begin
              add_r      = half_add(col_cur[c][0], col_cur[c][1]);
              col_cur[c] = col_cur[c] >> 2;
              n_cur[c]   = n_cur[c] - 2;
              col_h      = col_h - 1;
            end else begin
              add_r      = full_add(col_cur[c][0], col_cur[c][1], col_cur[c][2]);
              col_cur[c] = col_cur[c] >> 3;
              n_cur[c]   = n_cur[c] - 3;
              col_h      = col_h - 2;
            end
            col_nxt[c]   = col_nxt[c] | (MAXH'(add_r[0]) << n_nxt[c]);
            n_nxt[c]     = n_nxt[c] + 1;
            col_nxt[c+1] = col_nxt[c+1] | (MAXH'(add_r[1]) << n_nxt[c+1]);
            n_nxt[c+1]   = n_nxt[c+1] + 1;
          end
        end
        col_nxt[c] = col_nxt[c] | (col_cur[c] << n_nxt[c]);
        n_nxt[c]   = n_nxt[c] + n_cur[c];
      end
      for (int c = 0; c <= NCOL; c++) begin
        col_cur[c] = col_nxt[c];
        n_cur[c]   = n_nxt[c];
      end
    end

    red_sum   = '0;
    red_carry = '0;
    for (int c = 0; c < NCOL; c++) begin
      red_sum[c]   = col_cur[c][0];
      red_carry[c] = col_cur[c][1];
    end
  end

  // Pipeline next-state: everything holds on stall; data only moves with a valid token.
  always_comb begin
    v1_d     = stall ? v1_q : in_valid;
    v2_d     = stall ? v2_q : v1_q;
    v3_d     = stall ? v3_q : v2_q;

    a1_d     = a1_q;
    b1_d     = b1_q;
    sgn1_d   = sgn1_q;
    if (!stall && in_valid) begin
      a1_d   = in_a;
      b1_d   = in_b;
      sgn1_d = in_signed & SGN_OK;
    end

    sum2_d   = sum2_q;
    carry2_d = carry2_q;
    sgn2_d   = sgn2_q;
    if (!stall && v1_q) begin
      sum2_d   = red_sum;
      carry2_d = red_carry;
      sgn2_d   = sgn1_q;
    end

    p3_d     = p3_q;
    sgn3_d   = sgn3_q;
    if (!stall && v2_q) begin
      p3_d   = sum2_q + carry2_q;
      sgn3_d = sgn2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      p3_q   <= '0;
      sgn3_q <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      p3_q   <= p3_d;
      sgn3_q <= sgn3_d;
    end
  end

  always_ff @(posedge clk) begin
    a1_q     <= a1_d;
    b1_q     <= b1_d;
    sgn1_q   <= sgn1_d;
    sum2_q   <= sum2_d;
    carry2_q <= carry2_d;
    sgn2_q   <= sgn2_d;
  end

endmodule

// File: tb/tb_dadda_mult_pipe.sv
// Self-checking bench for dadda_mult_pipe: WIDTH=8 scenarios plus WIDTH=4/16 random sweeps
// against an integer-arithmetic product model.
module tb_dadda_mult_pipe;

  typedef longint unsigned u64_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_signed, out_valid, out_ready, out_signed;
  logic [7:0]  in_a, in_b;
  logic [15:0] out_p;

  logic        v4_in_valid, v4_in_ready, v4_in_signed, v4_out_valid, v4_out_ready, v4_out_signed;
  logic [3:0]  v4_in_a, v4_in_b;
  logic [7:0]  v4_out_p;

  logic        v16_in_valid, v16_in_ready, v16_in_signed, v16_out_valid, v16_out_ready, v16_out_signed;
  logic [15:0] v16_in_a, v16_in_b;
  logic [31:0] v16_out_p;

  dadda_mult_pipe #(.WIDTH(8), .SIGNED_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .out_valid(out_valid),
    .out_ready(out_ready), .out_p(out_p), .out_signed(out_signed));

  dadda_mult_pipe #(.WIDTH(4), .SIGNED_EN(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4_in_valid), .in_ready(v4_in_ready),
    .in_a(v4_in_a), .in_b(v4_in_b), .in_signed(v4_in_signed), .out_valid(v4_out_valid),
    .out_ready(v4_out_ready), .out_p(v4_out_p), .out_signed(v4_out_signed));

  dadda_mult_pipe #(.WIDTH(16), .SIGNED_EN(1)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16_in_valid), .in_ready(v16_in_ready),
    .in_a(v16_in_a), .in_b(v16_in_b), .in_signed(v16_in_signed), .out_valid(v16_out_valid),
    .out_ready(v16_out_ready), .out_p(v16_out_p), .out_signed(v16_out_signed));

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [15:0] q8  [$];
  bit          qs8 [$];
  logic [7:0]  q4  [$];
  logic [31:0] q16 [$];

  // Exact product of two w-bit operands, reduced modulo 2^(2w).
  function automatic u64_t ref_prod(input int w, input bit s, input u64_t a, input u64_t b);
    longint sa, sb;
    u64_t   mask;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    mask = (u64_t'(1) << (2 * w)) - 1;
    return u64_t'(sa * sb) & mask;
  endfunction

  // One cycle on the 8-bit DUT: drive at negedge, observe transfers, keep the scoreboard.
  task automatic step8(input bit iv, input logic [7:0] a, input logic [7:0] b, input bit s,
                       input bit ordy, output bit ox, output bit ix, output logic [15:0] act_p,
                       output bit act_s, output logic [15:0] exp_p, output bit exp_s,
                       output bit have_exp);
    @(negedge clk);
    in_valid = iv; in_a = a; in_b = b; in_signed = s; out_ready = ordy;
    #1;
    ox = out_valid && out_ready;
    ix = iv && in_ready;
    act_p = out_p;
    act_s = out_signed;
    exp_p = '0; exp_s = 1'b0; have_exp = 1'b0;
    if (ox && q8.size() > 0) begin
      exp_p = q8.pop_front();
      exp_s = qs8.pop_front();
      have_exp = 1'b1;
    end
    if (ix) begin
      q8.push_back(16'(ref_prod(8, s, u64_t'(a), u64_t'(b))));
      qs8.push_back(s);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_p !== 16'h0) begin n_fail++; $display("FAIL reset_out_p: got %h want 0000", out_p); end
    n_vec++; if (out_signed !== 1'b0) begin n_fail++; $display("FAIL reset_out_signed: got %b want 0", out_signed); end
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_corners();
    logic [7:0]  ta  [7] = '{8'd255, 8'd0,   8'h80, 8'hFF, 8'h7F, 8'hFF, 8'h00};
    logic [7:0]  tbv [7] = '{8'd255, 8'd200, 8'h80, 8'h01, 8'h80, 8'hFF, 8'h80};
    bit          ts  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] tp  [7] = '{16'hFE01, 16'h0000, 16'h4000, 16'hFFFF, 16'hC080, 16'h0001, 16'h0000};
    bit ox, ix, act_s, exp_s, he;
    logic [15:0] act_p, exp_p;
    for (int i = 0; i < 7; i++) begin
      step8(1'b1, ta[i], tbv[i], ts[i], 1'b1, ox, ix, act_p, act_s, exp_p, exp_s, he);
      n_vec++; if (ix !== 1'b1) begin n_fail++; $display("FAIL corner%0d_accept: got %b want 1", i, ix); end
      for (int k = 1; k <= 3; k++) begin
        step8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, ox, ix, act_p, act_s, exp_p, exp_s, he);
        n_vec++;
        if (k < 3) begin
          if (ox !== 1'b0) begin n_fail++; $display("FAIL corner%0d_early: out_valid at +%0d, want at +3", i, k); end
        end else if (ox !== 1'b1) begin
          n_fail++; $display("FAIL corner%0d_latency: out_valid %b at +3, want 1", i, ox);
        end else begin
          if (act_p !== tp[i]) begin n_fail++; $display("FAIL corner%0d_p: got %h want %h", i, act_p, tp[i]); end
          n_vec++;
          if (act_s !== ts[i]) begin n_fail++; $display("FAIL corner%0d_signed: got %b want %b", i, act_s, ts[i]); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ox, ix, act_s, exp_s, he;
    logic [15:0] act_p, exp_p;
    int cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step8(i < 16, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, ox, ix, act_p, act_s, exp_p, exp_s, he);
      if (ox) begin
        n_vec++;
        if (!he) begin n_fail++; $display("FAIL b2b_extra: unexpected product %h", act_p); end
        else if (i != 3 + cnt || act_p !== exp_p || act_s !== exp_s)
          begin n_fail++; $display("FAIL b2b_out%0d: got %h/%b at step %0d want %h/%b at step %0d", cnt, act_p, act_s, i, exp_p, exp_s, 3 + cnt); end
        cnt++;
      end
    end
    n_vec++; if (cnt != 16) begin n_fail++; $display("FAIL b2b_count: got %0d want 16", cnt); end
  endtask

  task automatic test_backpressure();
    bit ox, ix, act_s, exp_s, he;
    logic [15:0] act_p, exp_p, held_p;
    int cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, ox, ix, act_p, act_s, exp_p, exp_s, he);
      n_vec++; if (ix !== 1'b1) begin n_fail++; $display("FAIL bp_fill%0d: in accepted %b want 1", i, ix); end
    end
    held_p = 16'h0;
    for (int i = 0; i < 5; i++) begin
      step8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, ox, ix, act_p, act_s, exp_p, exp_s, he);
      n_vec++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready); end
      n_vec++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid%0d: got %b want 1", i, out_valid); end
      if (i == 0) held_p = act_p;
      else begin
        n_vec++; if (act_p !== held_p) begin n_fail++; $display("FAIL bp_hold%0d: got %h want %h", i, act_p, held_p); end
      end
    end
    for (int i = 0; i < 8; i++) begin
      step8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, ox, ix, act_p, act_s, exp_p, exp_s, he);
      if (ox) begin
        n_vec++;
        if (!he || act_p !== exp_p || act_s !== exp_s)
          begin n_fail++; $display("FAIL bp_drain%0d: got %h/%b want %h/%b", cnt, act_p, act_s, exp_p, exp_s); end
        cnt++;
      end
    end
    n_vec++; if (cnt != 3) begin n_fail++; $display("FAIL bp_drain_count: got %0d want 3", cnt); end
  endtask

  task automatic test_reset_midflight();
    bit ox, ix, act_s, exp_s, he;
    logic [15:0] act_p, exp_p;
    bit seen;
    for (int i = 0; i < 3; i++)
      step8(1'b1, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 1'b1, 1'b1, ox, ix, act_p, act_s, exp_p, exp_s, he);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    n_vec++; if (out_p !== 16'h0) begin n_fail++; $display("FAIL midrst_out_p: got %h want 0000", out_p); end
    n_vec++; if (out_signed !== 1'b0) begin n_fail++; $display("FAIL midrst_out_signed: got %b want 0", out_signed); end
    q8.delete();
    qs8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, ox, ix, act_p, act_s, exp_p, exp_s, he);
      if (out_valid) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_stale: out_valid seen %b want 0", seen); end
    step8(1'b1, 8'd13, 8'd11, 1'b0, 1'b1, ox, ix, act_p, act_s, exp_p, exp_s, he);
    for (int k = 1; k <= 3; k++) begin
      step8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, ox, ix, act_p, act_s, exp_p, exp_s, he);
      n_vec++;
      if (ox !== (k == 3)) begin n_fail++; $display("FAIL midrst_release_lat: out_valid %b at +%0d", ox, k); end
      else if (k == 3 && act_p !== 16'd143) begin n_fail++; $display("FAIL midrst_release_p: got %h want 008f", act_p); end
    end
  endtask

  task automatic test_random_stall();
    bit ox, ix, act_s, exp_s, he, prev_hold;
    logic [15:0] act_p, exp_p, prev_p;
    bit prev_s;
    prev_hold = 1'b0; prev_p = '0; prev_s = 1'b0;
    for (int i = 0; i < 320; i++) begin
      step8((i < 300) && ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom),
            (i >= 300) || ($urandom_range(0, 2) != 0), ox, ix, act_p, act_s, exp_p, exp_s, he);
      if (prev_hold) begin
        n_vec++;
        if (act_p !== prev_p || act_s !== prev_s)
          begin n_fail++; $display("FAIL rnd_hold step%0d: got %h/%b want %h/%b", i, act_p, act_s, prev_p, prev_s); end
      end
      if (ox) begin
        n_vec++;
        if (!he) begin n_fail++; $display("FAIL rnd_extra step%0d: unexpected product %h", i, act_p); end
        else if (act_p !== exp_p || act_s !== exp_s)
          begin n_fail++; $display("FAIL rnd_out step%0d: got %h/%b want %h/%b", i, act_p, act_s, exp_p, exp_s); end
      end
      prev_hold = out_valid && !out_ready;
      prev_p = act_p;
      prev_s = act_s;
    end
    n_vec++; if (q8.size() != 0) begin n_fail++; $display("FAIL rnd_lost: got %0d pending want 0", q8.size()); end
  endtask

  task automatic test_param_sweep();
    logic [7:0]  e4;
    logic [31:0] e16;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 10004; i++) begin
        @(negedge clk);
        v4_in_valid  = (i < 10000); v4_in_a  = 4'($urandom);  v4_in_b  = 4'($urandom);
        v4_in_signed = m[0];        v4_out_ready = 1'b1;
        v16_in_valid = (i < 10000); v16_in_a = 16'($urandom); v16_in_b = 16'($urandom);
        v16_in_signed = m[0];       v16_out_ready = 1'b1;
        #1;
        if (v4_out_valid) begin
          n_vec++;
          if (q4.size() == 0) begin n_fail++; $display("FAIL sweep4_extra: got %h", v4_out_p); end
          else begin
            e4 = q4.pop_front();
            if (v4_out_p !== e4) begin n_fail++; $display("FAIL sweep4 mode%0d: got %h want %h", m, v4_out_p, e4); end
          end
        end
        if (v16_out_valid) begin
          n_vec++;
          if (q16.size() == 0) begin n_fail++; $display("FAIL sweep16_extra: got %h", v16_out_p); end
          else begin
            e16 = q16.pop_front();
            if (v16_out_p !== e16) begin n_fail++; $display("FAIL sweep16 mode%0d: got %h want %h", m, v16_out_p, e16); end
          end
        end
        if (v4_in_valid && v4_in_ready)
          q4.push_back(8'(ref_prod(4, m[0], u64_t'(v4_in_a), u64_t'(v4_in_b))));
        if (v16_in_valid && v16_in_ready)
          q16.push_back(32'(ref_prod(16, m[0], u64_t'(v16_in_a), u64_t'(v16_in_b))));
      end
      n_vec++; if (q4.size() != 0) begin n_fail++; $display("FAIL sweep4_lost: got %0d pending want 0", q4.size()); end
      n_vec++; if (q16.size() != 0) begin n_fail++; $display("FAIL sweep16_lost: got %0d pending want 0", q16.size()); end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b1;
    v4_in_valid = 1'b0; v4_in_a = '0; v4_in_b = '0; v4_in_signed = 1'b0; v4_out_ready = 1'b1;
    v16_in_valid = 1'b0; v16_in_a = '0; v16_in_b = '0; v16_in_signed = 1'b0; v16_out_ready = 1'b1;
    #1;
    test_reset();
    test_corners();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random_stall();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/dadda_mult_pipe.md
DADDA_MULT_PIPE -- requirements
Module: dadda_mult_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 SHALL have parameter SIGNED_EN, default 1; 1 enables the signed mode, 0 ignores in_signed and treats it as 0.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  operand pair present.
REQ-007 in_ready  output  1  block accepts the operand pair this cycle.
REQ-008 in_a  input  WIDTH  multiplicand.
REQ-009 in_b  input  WIDTH  multiplier.
REQ-010 in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-011 out_valid  output  1  product present.
REQ-012 out_ready  input  1  consumer accepts the product.
REQ-013 out_p  output  2*WIDTH  product.
REQ-014 out_signed  output  1  in_signed value captured with this product.

Function
REQ-015 Transfer rules: input transfer occurs when in_valid and in_ready are both 1; output transfer occurs when out_valid and out_ready are both 1.
REQ-016 Pipeline structure: three register stages, each with its own valid bit v1, v2, v3.
- S1: registered operands and mode.
- S2: Dadda-reduced two-row result (sum row and carry row, each 2*WIDTH) from the S1 partial products.
- S3: carry-propagate sum driving out_p.
REQ-017 Reduction: partial products SHALL be reduced by a Dadda schedule.
- Reduction heights are 2,3,4,6,9,13,19,28..., with half and full adders only.
- The whole reduction completes combinationally between S1 and S2.
REQ-018 Signed mode SHALL use Baugh-Wooley partial products.
- Invert MSB-row and MSB-column cross terms.
- Add constant 1 at column WIDTH and at column 2*WIDTH-1.
- Result is exact two's-complement, 2*WIDTH bits.
REQ-019 Unsigned mode SHALL produce the exact unsigned 2*WIDTH-bit product; no truncation or saturation in either mode.
REQ-020 Latency: 3 cycles from input transfer to out_valid=1 when not stalled; throughput 1 product per cycle.
REQ-021 Stall: stall = v3 & ~out_ready. While stall=1, all three stages hold their contents and valid bits.
REQ-022 in_ready SHALL equal ~stall (combinational from out_ready and v3; no dependence on in_valid).
REQ-023 Bubbles: when stall=0, each stage loads from its predecessor, including valid=0 bubbles; S1 loads in_valid.
REQ-024 out_valid SHALL equal v3; out_p and out_signed SHALL equal the S3 contents.
REQ-025 Output stability: while out_valid=1 and out_ready=0, out_p and out_signed SHALL not change.
REQ-026 Ordering: products SHALL emerge in acceptance order; none dropped or duplicated.
REQ-027 Simultaneous events: an output transfer and an input transfer in the same cycle both complete.
REQ-028 Don't-care inputs: in_a, in_b and in_signed SHALL be ignored when in_valid=0 or in_ready=0.
REQ-029 Boundary operands: zero operands and all-ones operands in both modes SHALL give exact results, including the most-negative x most-negative case.

Reset
REQ-030 While rst_n=0, independent of clk: v1=v2=v3=0, out_valid=0, out_p=0, out_signed=0.
REQ-031 in_ready SHALL be 1 during reset and after it is released (no stall).
REQ-032 Reset mid-operation SHALL discard all in-flight products; no product accepted before the reset appears afterwards.
REQ-033 Release: the first input transfer after rst_n rises produces out_valid exactly 3 cycles later.

Verification (WIDTH=8 unless stated)
REQ-034 Unsigned corners, out_ready=1:
- in_a=255, in_b=255, in_signed=0 -> out_p=0xFE01 at cycle +3.
- 0 x 200 -> 0x0000.
REQ-035 Signed corners:
- -128 x -128 -> 0x4000.
- -1 x 1 -> 0xFFFF.
- 127 x -128 -> 0xC080.
- Each result has out_signed=1.
REQ-036 Streaming: 16 back-to-back transfers (random operands and modes), out_ready=1.
- 16 consecutive out_valid cycles in order, starting 3 cycles after the first transfer.
- Every result matches the reference product.
REQ-037 Backpressure: fill the pipe, then drop out_ready for 5 cycles.
- in_ready=0 throughout; out_p held constant.
- After out_ready rises, all 3 products drain in order with none lost.
REQ-038 Reset mid-flight: assert rst_n=0 asynchronously (between clock edges) with 3 products in flight.
- out_valid and out_p go to 0 immediately.
- No stale product is emitted after release.
REQ-039 Parameter sweep: WIDTH=4 and WIDTH=16, 10,000 random vectors per mode -> zero mismatches against the behavioural product.
